// File: rtl/microcode_sequencer.sv
// microcode_sequencer: fetches 19-bit microinstructions from the program ROM,
// decodes them into ALU op/operands, and writes the ALU result back into an
// 8x8-bit register file. Each instruction takes three cycles
// (FETCH, DECODE, EXEC); a run covers ROM words 0..PROG_LEN-1.
module microcode_sequencer #(
    parameter int unsigned PROG_LEN = 9
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [18:0] rom_data,
    input  logic [7:0]  alu_y,
    output logic [5:0]  rom_addr,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  result,
    output logic        result_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [5:0] LAST_PC = 6'(PROG_LEN - 1);

    state_t      state_q, state_d;
    logic [5:0]  pc_q, pc_d;
    logic [18:0] ir_q, ir_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic [7:0]  result_q, result_d;
    logic        rv_q, rv_d;
    logic [7:0]  rf_q [0:7];
    logic [7:0]  rf_d [0:7];

    // Instruction word fields
    logic [2:0]  ir_op;
    logic        ir_we;
    logic [2:0]  ir_rd;
    logic [2:0]  ir_ra;
    logic        ir_imm_sel;
    logic [7:0]  ir_imm;

    assign ir_op      = ir_q[18:16];
    assign ir_we      = ir_q[15];
    assign ir_rd      = ir_q[14:12];
    assign ir_ra      = ir_q[11:9];
    assign ir_imm_sel = ir_q[8];
    assign ir_imm     = ir_q[7:0];

    // Operand B is either the immediate or a register picked by imm[2:0];
    // the upper immediate bits are ignored in register mode.
    function automatic logic [7:0] sel_operand_b(input logic       imm_sel,
                                                 input logic [7:0] imm,
                                                 input logic [7:0] reg_val);
        return imm_sel ? imm : reg_val;
    endfunction

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = (pc_q == LAST_PC) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: pc, instruction register, ALU operands, writeback
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        result_d = result_q;
        rv_d     = 1'b0;
        rf_d     = rf_q;
        unique case (state_q)
            IDLE: begin
                if (start) pc_d = 6'd0;
            end
            FETCH: begin
                ir_d = rom_data;
            end
            DECODE: begin
                alu_op_d = ir_op;
                alu_a_d  = rf_q[ir_ra];
                alu_b_d  = sel_operand_b(ir_imm_sel, ir_imm, rf_q[ir_imm[2:0]]);
            end
            EXEC: begin
                result_d = alu_y;
                rv_d     = 1'b1;
                if (ir_we) rf_d[ir_rd] = alu_y;
                if (pc_q != LAST_PC) pc_d = pc_q + 6'd1;
            end
            DONE: begin
                pc_d = 6'd0;
            end
            default: begin
                pc_d = 6'd0;
            end
        endcase
    end

    // Datapath registers; everything clears on reset so an abandoned run
    // leaves no partial writeback behind.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= 6'd0;
            ir_q     <= 19'd0;
            alu_op_q <= 3'd0;
            alu_a_q  <= 8'd0;
            alu_b_q  <= 8'd0;
            result_q <= 8'd0;
            rv_q     <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= 8'd0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign rom_addr     = pc_q;
    assign alu_op       = alu_op_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: one instance with a 1-word program
// and one with a 3-word program, each fed by a bench-side ROM and ALU model.
module tb_microcode_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start1 = 1'b0;
    logic start3 = 1'b0;

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // ---- instance with PROG_LEN=1 ----
    logic [18:0] rom1_w;
    logic [18:0] rom_data1;
    logic [7:0]  alu_y1, alu_a1, alu_b1, result1;
    logic [5:0]  rom_addr1;
    logic [2:0]  alu_op1;
    logic        rv1, busy1, done1;

    // ---- instance with PROG_LEN=3 ----
    logic [18:0] rom3 [0:2];
    logic [18:0] rom_data3;
    logic [7:0]  alu_y3, alu_a3, alu_b3, result3;
    logic [5:0]  rom_addr3;
    logic [2:0]  alu_op3;
    logic        rv3, busy3, done3;

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~a;
            3'd5: return (b >= 8'd8) ? 8'd0 : (a << b[2:0]);
            3'd6: return (b >= 8'd8) ? 8'd0 : (a >> b[2:0]);
            default: return a + b + 8'd1;
        endcase
    endfunction

    function automatic logic [18:0] mkw(input logic [2:0] op, input logic we, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic imm_sel, input logic [7:0] imm);
        return {op, we, rd, ra, imm_sel, imm};
    endfunction

    assign rom_data1 = (rom_addr1 == 6'd0) ? rom1_w : 19'd0;
    assign rom_data3 = (rom_addr3 < 6'd3) ? rom3[rom_addr3[1:0]] : 19'd0;
    assign alu_y1 = alu(alu_op1, alu_a1, alu_b1);
    assign alu_y3 = alu(alu_op3, alu_a3, alu_b3);

    microcode_sequencer #(.PROG_LEN(1)) u_seq1 (
        .clock(clock), .reset(reset), .start(start1), .rom_data(rom_data1), .alu_y(alu_y1),
        .rom_addr(rom_addr1), .alu_op(alu_op1), .alu_a(alu_a1), .alu_b(alu_b1),
        .result(result1), .result_valid(rv1), .busy(busy1), .done(done1));

    microcode_sequencer #(.PROG_LEN(3)) u_seq3 (
        .clock(clock), .reset(reset), .start(start3), .rom_data(rom_data3), .alu_y(alu_y3),
        .rom_addr(rom_addr3), .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
        .result(result3), .result_valid(rv3), .busy(busy3), .done(done3));

    // Pulse counters and result log for the 3-word instance
    int         rv3_cnt = 0;
    int         done3_cnt = 0;
    logic [7:0] log3 [0:63];

    always @(negedge clock) begin
        if (rv3) begin
            log3[rv3_cnt[5:0]] <= result3;
            rv3_cnt <= rv3_cnt + 1;
        end
        if (done3) done3_cnt <= done3_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run3();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("fetch_rom_addr", 32'(rom_addr3), 32'h0);
        check("fetch_busy", 32'(busy3), 32'h1);
    endtask

    task automatic wait_done3();
        for (int i = 0; i < 40 && !done3; i++) tick();
        check("done3_seen", 32'(done3), 32'h1);
    endtask

    task automatic check_log(input string tag, input int base, input logic [7:0] e0,
                             input logic [7:0] e1, input logic [7:0] e2);
        check({tag, "_r0"}, 32'(log3[6'(base)]),     32'(e0));
        check({tag, "_r1"}, 32'(log3[6'(base + 1)]), 32'(e1));
        check({tag, "_r2"}, 32'(log3[6'(base + 2)]), 32'(e2));
    endtask

    int base_rv, base_done;

    initial begin
        rom1_w = 19'd0;
        rom3[0] = 19'd0; rom3[1] = 19'd0; rom3[2] = 19'd0;

        // Reset asserted mid-cycle, with no clock edge yet
        #2 reset = 1'b1;
        #1;
        check("rst_rom_addr", 32'(rom_addr3), 32'h0);
        check("rst_outputs", 32'({alu_op3, alu_a3, alu_b3, result3}), 32'h0);
        check("rst_flags", 32'({rv3, busy3, done3}), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Immediate load with PROG_LEN=1: r1 = r0 | 0x05
        rom1_w = mkw(3'd2, 1'b1, 3'd1, 3'd0, 1'b1, 8'h05);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("p1_busy", 32'(busy1), 32'h1);
        tick();
        tick();
        check("p1_exec_alu", 32'({alu_op1, alu_a1, alu_b1}), 32'({3'd2, 8'h00, 8'h05}));
        tick();
        check("p1_result", 32'(result1), 32'h05);
        check("p1_valid_done", 32'({rv1, done1}), 32'h3);
        tick();
        check("p1_idle", 32'({rv1, done1, busy1}), 32'h0);
        // Read r1 back: r1 + 0, no write
        rom1_w = mkw(3'd0, 1'b0, 3'd0, 3'd1, 1'b1, 8'h00);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        check("p1_r1_readback", 32'(result1), 32'h05);

        // Dependency and wrap-around, start pulse during EXEC ignored
        rom3[0] = mkw(3'd2, 1'b1, 3'd1, 3'd0, 1'b1, 8'hF0);
        rom3[1] = mkw(3'd2, 1'b1, 3'd2, 3'd0, 1'b1, 8'h20);
        rom3[2] = mkw(3'd0, 1'b1, 3'd3, 3'd1, 1'b0, 8'hFA);  // rb = r2, imm[7:3] ignored
        base_rv = rv3_cnt; base_done = done3_cnt;
        start_run3();
        tick();
        tick();
        check("a_exec_alu", 32'({alu_op3, alu_a3, alu_b3}), 32'({3'd2, 8'h00, 8'hF0}));
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("a_first_valid", 32'({rv3, result3}), 32'({1'b1, 8'hF0}));
        check("a_pc_inc", 32'(rom_addr3), 32'h1);
        for (int i = 0; i < 6; i++) tick();
        check("a_done_edge9", 32'(done3), 32'h1);
        check("a_last_result", 32'({rv3, result3}), 32'({1'b1, 8'h10}));
        tick();
        check("a_busy_fall", 32'({busy3, done3, rv3}), 32'h0);
        tick();
        check("a_no_restart", 32'(busy3), 32'h0);
        check("a_valid_cnt", 32'(rv3_cnt - base_rv), 32'd3);
        check("a_done_cnt", 32'(done3_cnt - base_done), 32'd1);
        check_log("a", base_rv, 8'hF0, 8'h20, 8'h10);

        // Shift and no-write: r1=0x81, shl 1 without write, shr 9 into r5
        rom3[0] = mkw(3'd2, 1'b1, 3'd1, 3'd0, 1'b1, 8'h81);
        rom3[1] = mkw(3'd5, 1'b0, 3'd1, 3'd1, 1'b1, 8'h01);
        rom3[2] = mkw(3'd6, 1'b1, 3'd5, 3'd1, 1'b1, 8'h09);
        base_rv = rv3_cnt;
        start_run3();
        wait_done3();
        tick();
        check_log("b", base_rv, 8'h81, 8'h02, 8'h00);

        // start held high through DONE; reads r1 to confirm it stayed 0x81
        rom3[0] = mkw(3'd2, 1'b1, 3'd2, 3'd1, 1'b1, 8'h00);  // r2 = r1
        rom3[1] = mkw(3'd0, 1'b1, 3'd3, 3'd1, 1'b0, 8'h05);  // r3 = r1 + r5
        rom3[2] = mkw(3'd3, 1'b1, 3'd4, 3'd2, 1'b1, 8'hFF);  // r4 = r2 ^ 0xFF
        base_rv = rv3_cnt; base_done = done3_cnt;
        start3 = 1'b1;
        tick();
        wait_done3();
        tick();
        check("c_idle_between", 32'(busy3), 32'h0);
        tick();
        check("c_restart", 32'({busy3, rom_addr3}), 32'({1'b1, 6'd0}));
        start3 = 1'b0;
        wait_done3();
        tick();
        check("c_valid_cnt", 32'(rv3_cnt - base_rv), 32'd6);
        check("c_done_cnt", 32'(done3_cnt - base_done), 32'd2);
        check_log("c1", base_rv, 8'h81, 8'h81, 8'h7E);
        check_log("c2", base_rv + 3, 8'h81, 8'h81, 8'h7E);

        // Reset during DECODE of instruction 1
        rom3[0] = mkw(3'd2, 1'b1, 3'd1, 3'd0, 1'b1, 8'h11);
        rom3[1] = mkw(3'd2, 1'b1, 3'd2, 3'd0, 1'b1, 8'h22);
        rom3[2] = mkw(3'd2, 1'b1, 3'd3, 3'd0, 1'b1, 8'h33);
        start_run3();
        for (int i = 0; i < 4; i++) tick();
        check("d_pre_reset", 32'({rom_addr3, result3}), 32'({6'd1, 8'h11}));
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("d_rst_outputs", 32'({alu_op3, alu_a3, alu_b3, result3}), 32'h0);
        check("d_rst_flags", 32'({rom_addr3, rv3, busy3, done3}), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        base_rv = rv3_cnt;
        for (int i = 0; i < 6; i++) tick();
        check("d_no_valid", 32'(rv3_cnt - base_rv), 32'd0);
        check("d_idle", 32'(busy3), 32'h0);
        // Registers read back as zero and the run starts at address 0
        rom3[0] = mkw(3'd2, 1'b1, 3'd6, 3'd1, 1'b1, 8'h00);  // r1
        rom3[1] = mkw(3'd2, 1'b1, 3'd6, 3'd2, 1'b1, 8'h00);  // r2
        rom3[2] = mkw(3'd0, 1'b1, 3'd7, 3'd3, 1'b0, 8'h04);  // r3 + r4
        base_rv = rv3_cnt;
        start_run3();
        wait_done3();
        tick();
        check("d_valid_cnt", 32'(rv3_cnt - base_rv), 32'd3);
        check_log("d", base_rv, 8'h00, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
